// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: slice handshake from the upstream producer plus the
// skewed edge buses toward the wavefront systolic array.
// Handshake: a slice transfers in every cycle where s_valid and s_ready are
// both 1; s_a/s_b are meaningful only while s_valid is 1, and s_ready does
// not depend on s_valid.
interface systolic_feeder_if #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 4,
    parameter int COLS   = 4
);
    logic                     s_valid;
    logic                     s_ready;
    logic [ROWS*DATA_W-1:0]   s_a;
    logic [COLS*DATA_W-1:0]   s_b;
    logic [ROWS*DATA_W-1:0]   a_in_bus;
    logic [COLS*DATA_W-1:0]   b_in_bus;
    logic                     valid_in;

    // Producer / bench side
    modport master (
        output s_valid, s_a, s_b,
        input  s_ready, a_in_bus, b_in_bus, valid_in
    );

    // Feeder side
    modport slave (
        input  s_valid, s_a, s_b,
        output s_ready, a_in_bus, b_in_bus, valid_in
    );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: accepts one k-slice (A column + B row) per handshake and
// applies the triangular skew for the systolic array: A lane i and B lane j
// are delayed by i and j extra cycles. After the last slice, zeros are
// flushed for max(ROWS,COLS) cycles and done pulses for one cycle.
// Optional feature macro: SYSTOLIC_FEEDER_PERF_EN enables the bubble counter;
// without it bubble_cnt is tied to 0.
// The interface instance must use the same DATA_W/ROWS/COLS as this module.
module systolic_feeder #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int K_MAX  = 16,
    localparam int KW    = $clog2(K_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KW-1:0]       k_len,
    systolic_feeder_if.slave    sif,
    output logic                busy,
    output logic                done,
    output logic [15:0]         bubble_cnt,
    output logic [1:0]          dbg_state
);

    localparam int D  = (ROWS > COLS) ? ROWS : COLS;
    localparam int FW = $clog2(D + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   klen_q, klen_d;
    logic [KW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   flush_q, flush_d;
    logic            done_q, done_d;
    logic            valid_q;
    logic            beat;
    logic [KW-1:0]   klen_clamp;

    assign beat       = (state_q == FEED) && sif.s_valid;
    assign klen_clamp = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;

    // Control registers: state, job length, beat and flush counters, done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            klen_q  <= '0;
            cnt_q   <= '0;
            flush_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: start is only honoured in IDLE, so a start while busy
    // falls through untouched
    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        klen_d  = klen_clamp;
                        cnt_d   = '0;
                        state_d = FEED;
                    end
                end
            end
            FEED: begin
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == klen_q) begin
                        state_d = FLUSH;
                        flush_d = '0;
                    end
                end
            end
            FLUSH: begin
                if (flush_q == FW'(D - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Wavefront valid: one register fed by the beat flag
    always_ff @(posedge clk) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= beat;
    end

    // A skew lines: lane i is i+1 registers deep; zeros enter on non-beat cycles
    for (genvar i = 0; i < ROWS; i++) begin : g_a
        logic [DATA_W-1:0] sr_q [0:i];
        logic [DATA_W-1:0] lane_d;
        assign lane_d = beat ? sif.s_a[(i+1)*DATA_W-1 -: DATA_W] : '0;
        // Shift every cycle; no stall toward the array
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= i; k++) sr_q[k] <= '0;
            end else begin
                sr_q[0] <= lane_d;
                for (int k = 1; k <= i; k++) sr_q[k] <= sr_q[k-1];
            end
        end
        assign sif.a_in_bus[(i+1)*DATA_W-1 -: DATA_W] = sr_q[i];
    end

    // B skew lines: lane j is j+1 registers deep
    for (genvar j = 0; j < COLS; j++) begin : g_b
        logic [DATA_W-1:0] sr_q [0:j];
        logic [DATA_W-1:0] lane_d;
        assign lane_d = beat ? sif.s_b[(j+1)*DATA_W-1 -: DATA_W] : '0;
        // Shift every cycle; no stall toward the array
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= j; k++) sr_q[k] <= '0;
            end else begin
                sr_q[0] <= lane_d;
                for (int k = 1; k <= j; k++) sr_q[k] <= sr_q[k-1];
            end
        end
        assign sif.b_in_bus[(j+1)*DATA_W-1 -: DATA_W] = sr_q[j];
    end

`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [15:0] bubble_q, bubble_d;

    // Bubble counter: FEED cycles without s_valid, saturating, cleared by start
    always_comb begin
        bubble_d = bubble_q;
        if (state_q == IDLE && start) begin
            bubble_d = '0;
        end else if (state_q == FEED && !sif.s_valid && bubble_q != 16'hFFFF) begin
            bubble_d = bubble_q + 16'd1;
        end
    end

    // Bubble counter register
    always_ff @(posedge clk) begin
        if (rst) bubble_q <= '0;
        else     bubble_q <= bubble_d;
    end

    assign bubble_cnt = bubble_q;
`else
    assign bubble_cnt = '0;
`endif

    assign sif.s_ready  = (state_q == FEED);
    assign sif.valid_in = valid_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed scenarios plus randomized jobs, checked every
// cycle against a cycle-indexed history model of what was accepted.
module tb_systolic_feeder;

    localparam int W  = 8;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int D  = 4;
    localparam int HN = 4096;
    localparam int VW = R*W + C*W + 4 + 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [4:0]    k_len;
    logic          busy;
    logic          done;
    logic [15:0]   bubble_cnt;
    logic [1:0]    dbg_state;

    systolic_feeder_if #(.DATA_W(W), .ROWS(R), .COLS(C)) sif ();

    systolic_feeder #(.DATA_W(W), .ROWS(R), .COLS(C), .K_MAX(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .k_len      (k_len),
        .sif        (sif.slave),
        .busy       (busy),
        .done       (done),
        .bubble_cnt (bubble_cnt),
        .dbg_state  (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Bookkeeping
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: what was pushed in each cycle, plus job-level counts
    logic [R*W-1:0] a_hist [HN];
    logic [C*W-1:0] b_hist [HN];
    logic           v_hist [HN];
    int             floor_c   = 0;
    bit             m_active  = 0;
    int             m_left    = 0;
    int             m_done_at = -1;
    logic [15:0]    m_bubble  = '0;

    logic           exp_ready, exp_busy, exp_done;
    logic [VW-1:0]  exp_vec;
    logic [VW-1:0]  obs_vec;

    assign obs_vec = {sif.a_in_bus, sif.b_in_bus, sif.valid_in, sif.s_ready,
                      busy, done, bubble_cnt};

    // Apply the current cycle's inputs to the model
    task automatic model_commit();
        bit bt;
        if (rst) begin
            m_active  = 0;
            m_left    = 0;
            m_done_at = -1;
            m_bubble  = '0;
            floor_c   = cyc + 1;
            a_hist[cyc] = '0;
            b_hist[cyc] = '0;
            v_hist[cyc] = 1'b0;
        end else begin
            bt = sif.s_valid && exp_ready;
            a_hist[cyc] = bt ? sif.s_a : '0;
            b_hist[cyc] = bt ? sif.s_b : '0;
            v_hist[cyc] = bt;
`ifdef SYSTOLIC_FEEDER_PERF_EN
            if (exp_ready && !sif.s_valid && m_bubble != 16'hFFFF) m_bubble = m_bubble + 16'd1;
`endif
            if (bt) begin
                m_left = m_left - 1;
                if (m_left == 0) m_done_at = cyc + D + 1;
            end
            if (!exp_busy && start) begin
                m_bubble = '0;
                if (k_len == 0) m_done_at = cyc + 1;
                else begin
                    m_active = 1;
                    m_left   = (k_len > 16) ? 16 : int'(k_len);
                end
            end
            if (m_done_at == cyc + 1) m_active = 0;
        end
    endtask

    // Expected outputs for the current cycle
    task automatic model_expect();
        logic [R*W-1:0] ea;
        logic [C*W-1:0] eb;
        logic           ev;
        int idx;
        exp_ready = m_active && (m_left > 0);
        exp_busy  = m_active;
        exp_done  = (cyc == m_done_at);
        for (int i = 0; i < R; i++) begin
            idx = cyc - 1 - i;
            ea[i*W +: W] = (idx >= floor_c && idx >= 0) ? a_hist[idx][i*W +: W] : '0;
        end
        for (int j = 0; j < C; j++) begin
            idx = cyc - 1 - j;
            eb[j*W +: W] = (idx >= floor_c && idx >= 0) ? b_hist[idx][j*W +: W] : '0;
        end
        ev = (cyc - 1 >= floor_c && cyc >= 1) ? v_hist[cyc-1] : 1'b0;
        exp_vec = {ea, eb, ev, exp_ready, exp_busy, exp_done, m_bubble};
    endtask

    // Advance one clock: commit inputs, then sample #1 after the edge
    task automatic step();
        model_commit();
        @(posedge clk);
        #1;
        cyc++;
        model_expect();
    endtask

    // Driver tasks
    task automatic drive_idle();
        start       = 1'b0;
        k_len       = '0;
        sif.s_valid = 1'b0;
        sif.s_a     = '0;
        sif.s_b     = '0;
    endtask

    task automatic drive_rand_slice(input bit v);
        sif.s_valid = v;
        for (int i = 0; i < R; i++) sif.s_a[i*W +: W] = 8'($urandom);
        for (int j = 0; j < C; j++) sif.s_b[j*W +: W] = 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        for (int n = 0; n < 3; n++) begin
            step();
            n_checks++;
            if (obs_vec !== {VW{1'b0}}) $display("FAIL reset_outputs c=%0d got %h want 0", cyc, obs_vec); else n_pass++;
        end
        n_checks++;
        if (dbg_state !== 2'd0) $display("FAIL reset_state got %0d want 0", dbg_state); else n_pass++;
        rst = 1'b0;
        step();
        n_checks++;
        if (obs_vec !== exp_vec) $display("FAIL reset_release got %h want %h", obs_vec, exp_vec); else n_pass++;
    endtask

    task automatic test_basic_skew();
        int t0, rel;
        start = 1'b1; k_len = 5'd3;
        step();
        start = 1'b0;
        t0 = cyc;
        for (int n = 0; n < 10; n++) begin
            if (n < 3) begin
                sif.s_valid = 1'b1;
                for (int i = 0; i < R; i++) sif.s_a[i*W +: W] = 8'(10*n + i);
                for (int j = 0; j < C; j++) sif.s_b[j*W +: W] = 8'(100 + 10*n + j);
            end else begin
                drive_rand_slice(1'b0);
            end
            step();
            rel = cyc - t0;
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL basic_cycle c=%0d got %h want %h", cyc, obs_vec, exp_vec); else n_pass++;
            if (rel >= 3 && rel <= 5) begin
                n_checks++;
                if (sif.a_in_bus[23:16] !== 8'(10*(rel-3) + 2)) $display("FAIL basic_a_lane2 rel=%0d got %0d want %0d", rel, sif.a_in_bus[23:16], 10*(rel-3)+2); else n_pass++;
            end
            if (rel >= 4 && rel <= 6) begin
                n_checks++;
                if (sif.b_in_bus[31:24] !== 8'(100 + 10*(rel-4) + 3)) $display("FAIL basic_b_lane3 rel=%0d got %0d want %0d", rel, sif.b_in_bus[31:24], 100+10*(rel-4)+3); else n_pass++;
            end
            n_checks++;
            if (sif.valid_in !== (rel <= 3)) $display("FAIL basic_valid rel=%0d got %b want %b", rel, sif.valid_in, rel <= 3); else n_pass++;
            n_checks++;
            if (done !== (rel == 7)) $display("FAIL basic_done rel=%0d got %b want %b", rel, done, rel == 7); else n_pass++;
        end
    endtask

    task automatic test_bubble();
        int t0, rel;
        logic [7:0] exp_l0 [4];
        logic       exp_v  [4];
        exp_l0[0] = 8'h11; exp_l0[1] = 8'h00; exp_l0[2] = 8'h00; exp_l0[3] = 8'h22;
        exp_v[0]  = 1'b1;  exp_v[1]  = 1'b0;  exp_v[2]  = 1'b0;  exp_v[3]  = 1'b1;
        start = 1'b1; k_len = 5'd2;
        step();
        start = 1'b0;
        t0 = cyc;
        for (int n = 0; n < 11; n++) begin
            drive_rand_slice(n == 0 || n == 3);
            if (n == 0) sif.s_a[7:0] = 8'h11;
            if (n == 3) sif.s_a[7:0] = 8'h22;
            step();
            rel = cyc - t0;
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL bubble_cycle c=%0d got %h want %h", cyc, obs_vec, exp_vec); else n_pass++;
            if (rel >= 1 && rel <= 4) begin
                n_checks++;
                if (sif.a_in_bus[7:0] !== exp_l0[rel-1]) $display("FAIL bubble_lane0 rel=%0d got %h want %h", rel, sif.a_in_bus[7:0], exp_l0[rel-1]); else n_pass++;
                n_checks++;
                if (sif.valid_in !== exp_v[rel-1]) $display("FAIL bubble_valid rel=%0d got %b want %b", rel, sif.valid_in, exp_v[rel-1]); else n_pass++;
            end
            if (rel == 4) begin
                n_checks++;
`ifdef SYSTOLIC_FEEDER_PERF_EN
                if (bubble_cnt !== 16'd2) $display("FAIL bubble_cnt got %0d want 2", bubble_cnt); else n_pass++;
`else
                if (bubble_cnt !== 16'd0) $display("FAIL bubble_cnt got %0d want 0", bubble_cnt); else n_pass++;
`endif
            end
        end
        drive_idle();
    endtask

    task automatic test_zero_len();
        start = 1'b1; k_len = 5'd0;
        step();
        start = 1'b0;
        n_checks++;
        if ({done, busy, sif.s_ready} !== 3'b100) $display("FAIL zero_len_done got %b want 100", {done, busy, sif.s_ready}); else n_pass++;
        for (int n = 0; n < 4; n++) begin
            drive_rand_slice(1'b1);
            step();
            n_checks++;
            if ({done, busy, sif.s_ready} !== 3'b000) $display("FAIL zero_len_idle c=%0d got %b want 000", cyc, {done, busy, sif.s_ready}); else n_pass++;
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL zero_len_cycle c=%0d got %h want %h", cyc, obs_vec, exp_vec); else n_pass++;
        end
        drive_idle();
    endtask

    task automatic test_oversize();
        int beats = 0;
        start = 1'b1; k_len = 5'd20;
        step();
        start = 1'b0;
        for (int n = 0; n < 30; n++) begin
            drive_rand_slice(1'b1);
            step();
            if (sif.valid_in === 1'b1) beats++;
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL oversize_cycle c=%0d got %h want %h", cyc, obs_vec, exp_vec); else n_pass++;
        end
        n_checks++;
        if (beats !== 16) $display("FAIL oversize_beats got %0d want 16", beats); else n_pass++;
        drive_idle();
    endtask

    task automatic test_start_ignored();
        int t0, rel;
        int beats = 0;
        start = 1'b1; k_len = 5'd3;
        step();
        t0 = cyc;
        for (int n = 0; n < 11; n++) begin
            drive_rand_slice(n < 3);
            start = (n == 1);
            k_len = (n == 1) ? 5'd7 : 5'd3;
            step();
            rel = cyc - t0;
            if (sif.valid_in === 1'b1) beats++;
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL ignore_cycle c=%0d got %h want %h", cyc, obs_vec, exp_vec); else n_pass++;
            n_checks++;
            if (done !== (rel == 7)) $display("FAIL ignore_done rel=%0d got %b want %b", rel, done, rel == 7); else n_pass++;
        end
        n_checks++;
        if (beats !== 3) $display("FAIL ignore_beats got %0d want 3", beats); else n_pass++;
        drive_idle();
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        start = 1'b1; k_len = 5'd4;
        step();
        start = 1'b0;
        for (int n = 0; n < 2; n++) begin
            drive_rand_slice(1'b1);
            step();
        end
        rst = 1'b1;
        drive_rand_slice(1'b1);
        step();
        rst = 1'b0;
        drive_idle();
        n_checks++;
        if (obs_vec !== {VW{1'b0}}) $display("FAIL rstmid_outputs got %h want 0", obs_vec); else n_pass++;
        n_checks++;
        if (dbg_state !== 2'd0) $display("FAIL rstmid_state got %0d want 0", dbg_state); else n_pass++;
        for (int n = 0; n < 12; n++) begin
            step();
            n_checks++;
            if (done !== 1'b0) $display("FAIL rstmid_no_done c=%0d got %b want 0", cyc, done); else n_pass++;
        end
        start = 1'b1; k_len = 5'd3;
        step();
        start = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            drive_rand_slice($urandom_range(0, 3) != 0);
            step();
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL rstmid_fresh c=%0d got %h want %h", cyc, obs_vec, exp_vec); else n_pass++;
            if (exp_done) seen = 1;
        end
        n_checks++;
        if (!seen) $display("FAIL rstmid_fresh_done got none want pulse"); else n_pass++;
        drive_idle();
    endtask

    task automatic test_back_to_back();
        bit seen = 0;
        int t1, rel;
        start = 1'b1; k_len = 5'd2;
        step();
        start = 1'b0;
        for (int n = 0; n < 12 && !seen; n++) begin
            drive_rand_slice(n < 2);
            step();
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL b2b_first c=%0d got %h want %h", cyc, obs_vec, exp_vec); else n_pass++;
            if (exp_done) seen = 1;
        end
        n_checks++;
        if (done !== 1'b1) $display("FAIL b2b_done got %b want 1", done); else n_pass++;
        start = 1'b1; k_len = 5'd2;
        drive_idle();
        start = 1'b1; k_len = 5'd2;
        step();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy); else n_pass++;
        t1 = cyc;
        for (int n = 0; n < 10; n++) begin
            drive_rand_slice(n < 2);
            if (n == 0) sif.s_a[31:24] = 8'h5A;
            step();
            rel = cyc - t1;
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL b2b_second c=%0d got %h want %h", cyc, obs_vec, exp_vec); else n_pass++;
            if (rel == 4) begin
                n_checks++;
                if (sif.a_in_bus[31:24] !== 8'h5A) $display("FAIL b2b_a_lane3 got %h want 5a", sif.a_in_bus[31:24]); else n_pass++;
            end
        end
        drive_idle();
    endtask

    task automatic test_random();
        bit seen;
        for (int job = 0; job < 8; job++) begin
            drive_idle();
            start = 1'b1;
            k_len = 5'($urandom_range(0, 20));
            step();
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL rand_start job=%0d got %h want %h", job, obs_vec, exp_vec); else n_pass++;
            seen = exp_done;
            for (int n = 0; n < 80 && !seen; n++) begin
                drive_rand_slice($urandom_range(0, 3) != 0);
                start = exp_busy && ($urandom_range(0, 7) == 0);
                k_len = 5'($urandom_range(0, 31));
                step();
                n_checks++;
                if (obs_vec !== exp_vec) $display("FAIL rand_cycle job=%0d c=%0d got %h want %h", job, cyc, obs_vec, exp_vec); else n_pass++;
                if (exp_done) seen = 1;
            end
            n_checks++;
            if (!seen) $display("FAIL rand_timeout job=%0d got no done want done", job); else n_pass++;
        end
        drive_idle();
        for (int n = 0; n < 3; n++) step();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        model_expect();
        test_reset();
        test_basic_skew();
        test_bubble();
        test_zero_len();
        test_oversize();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
